crossbar_arb4: RTL and testbench
================================

Name: crossbar_arb4

Overview:
- Control-side companion of the 4x4 data crossbar: arbitrates input-port requests for output ports and drives the crossbar's per-output 2-bit selects.
- Each input presents val / dest / tail. Each output gives back rdy. The block returns per-input rdy and per-output val.
- Uses per-output round-robin arbitration with wormhole locking, so a multi-flit packet holds its output until its tail flit transfers.
- Sits beside the data crossbar in the on-chip interconnect. The crossbar stays purely combinational; all routing state lives here.

Parameters:
- p_reset_ptr, 0: priority pointer value of every output after reset; input p_reset_ptr has highest priority.
- p_lock_en, 1: 1 = wormhole locking enabled; 0 = every flit treated as tail, so there is no locking.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_val  input  4  bit i: input i presents a flit
- in_dest  input  8  bits [2i+1:2i]: destination output of input i
- in_tail  input  4  bit i: flit on input i is last of its packet
- in_rdy  output  4  bit i: flit on input i transfers this cycle if in_val[i]
- out_val  output  4  bit o: output o carries a valid flit
- out_rdy  input  4  bit o: downstream of output o accepts
- sel0, sel1, sel2, sel3  output  2 each  select for crossbar outputs 0..3

Behaviour:
- Request: req[o][i] = in_val[i] && in_dest[i]==o.
- Per-output state:
  - st_o ∈ {IDLE, LOCKED}
  - owner_o (2b)
  - ptr_o (2b)
  - last_sel_o (2b)
- Reset (reset_n=0, asynchronous):
  - st_o=IDLE, owner_o=0, ptr_o=p_reset_ptr, last_sel_o=0.
  - While reset_n=0, outputs are forced: out_val=0, in_rdy=0, sel*=0.
- IDLE grant: first i with req[o][i], searching ptr_o, ptr_o+1, ... mod 4.
- LOCKED grant: owner_o only if req[o][owner_o]; no other input is granted, even if requesting.
- Outputs (combinational, zero latency):
  - out_val[o] = grant exists.
  - sel_o = grant index; when no grant, sel_o = last_sel_o.
- in_rdy[i] = (i is granted by output in_dest[i]) && out_rdy[in_dest[i]].
  - in_rdy[i] does not depend on in_val[i] beyond the grant.
- Transfer on o: out_val[o] && out_rdy[o]. On transfer, at the next edge:
  - last_sel_o <= grant.
  - If in_tail[grant] or p_lock_en==0: st_o <= IDLE, ptr_o <= grant+1 (2-bit wrap, 3→0).
  - Else: st_o <= LOCKED, owner_o <= grant; ptr_o unchanged.
- No transfer (out_val=0 or out_rdy=0): all state of o holds; an IDLE grant may change next cycle.
- Owner drops in_val or changes dest while LOCKED: out_val[o]=0, the lock holds, and other inputs stay blocked. Redirecting mid-packet is a protocol violation; no recovery is attempted.
- Outputs are independent: up to 4 transfers per cycle, at most one per input, since each input has one dest.
- Reset asserted mid-packet: locks are dropped immediately. Upstream must also reset.

Optional Feature:
- Macro: CROSSBAR_ARB_DOMAIN_EN.
- When defined, adds ports:
  - in_domain  input  4  security level of input i (0=L, 1=H)
  - out_domain  input  4  level of output o
  - viol  output  4  violation flag per input
- Eligibility: req[o][i] additionally requires in_domain[i] <= out_domain[o]. H→L requests are never granted.
- viol[i] is a registered 1-cycle pulse on the cycle after an ineligible val request is seen. It repeats each cycle the request persists. Reset value 0.
- When undefined: ports are absent and all requests are eligible.

Test Plan:
- Single flit: in_val=0001, in_dest[1:0]=2, tail=1, out_rdy=1111 -> same cycle: out_val=0100, sel2=0, in_rdy=0001; next cycle ptr2=1.
- Round-robin: inputs 0..3 all target output 1 with single-flit packets held for 4 cycles, out_rdy=1111 -> grants in order 0,1,2,3; sel1 sequence 0,1,2,3.
- Wormhole: input 2 sends a 3-flit packet to output 3 (tail on 3rd) while input 0 also requests output 3 -> input 2 granted 3 consecutive cycles; input 0 granted on cycle 4.
- Backpressure: out_rdy[0]=0 for 5 cycles with input 1 requesting output 0 -> out_val[0]=1, in_rdy=0000, sel0=1 held. out_rdy[0] rises -> single transfer.
- Async reset: assert reset_n=0 mid-packet between clock edges -> out_val=0000, in_rdy=0000, sel*=0 immediately. After release, input 0 wins a contested output (p_reset_ptr=0).
- With CROSSBAR_ARB_DOMAIN_EN: in_domain=0010, out_domain=0000, input 1 requests output 0 -> out_val[0]=0, in_rdy[1]=0, viol[1]=1 next cycle. Input 0 (L) to output 0 is granted normally.

Source files
------------

// File: rtl/crossbar_arb4.sv
// crossbar_arb4: per-output round-robin arbiter with wormhole locking for a 4x4 crossbar.
// Define CROSSBAR_ARB_DOMAIN_EN to add security-domain eligibility and per-input violation flags.
module crossbar_arb4 #(
    parameter logic [1:0] p_reset_ptr = 2'd0,
    parameter bit         p_lock_en   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] in_val,
    input  logic [7:0] in_dest,
    input  logic [3:0] in_tail,
    output logic [3:0] in_rdy,
    output logic [3:0] out_val,
    input  logic [3:0] out_rdy,
    output logic [1:0] sel0,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3
`ifdef CROSSBAR_ARB_DOMAIN_EN
    ,
    input  logic [3:0] in_domain,
    input  logic [3:0] out_domain,
    output logic [3:0] viol
`endif
);
    typedef enum logic {IDLE, LOCKED} st_t;
    st_t        st [4];
    logic [1:0] owner [4];
    logic [1:0] ptr [4];
    logic [1:0] last_sel [4];
    logic [1:0] gnt [4];
    logic [1:0] sel [4];
    logic [3:0] req [4];
    logic [3:0] gv;
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) begin
`ifdef CROSSBAR_ARB_DOMAIN_EN
                req[o][i] = in_val[i] && in_dest[2*i +: 2] == 2'(o) && !(in_domain[i] && !out_domain[o]);
`else
                req[o][i] = in_val[i] && in_dest[2*i +: 2] == 2'(o);
`endif
            end
        end
        for (int o = 0; o < 4; o++) begin
            gv[o]  = 1'b0;
            gnt[o] = ptr[o];
            if (st[o] == LOCKED) begin
                gv[o]  = req[o][owner[o]];
                gnt[o] = owner[o];
            end else begin
                // walk from the far end so the closest-to-pointer requester wins
                for (int k = 3; k >= 0; k--) begin
                    if (req[o][ptr[o] + 2'(k)]) begin
                        gv[o]  = 1'b1;
                        gnt[o] = ptr[o] + 2'(k);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++)
            in_rdy[i] = reset_n && gv[in_dest[2*i +: 2]] && gnt[in_dest[2*i +: 2]] == 2'(i)
                        && out_rdy[in_dest[2*i +: 2]];
        for (int o = 0; o < 4; o++) begin
            out_val[o] = reset_n && gv[o];
            sel[o]     = !reset_n ? 2'd0 : gv[o] ? gnt[o] : last_sel[o];
        end
    end
    assign sel0 = sel[0];
    assign sel1 = sel[1];
    assign sel2 = sel[2];
    assign sel3 = sel[3];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < 4; o++) begin
                st[o]       <= IDLE;
                owner[o]    <= 2'd0;
                ptr[o]      <= p_reset_ptr;
                last_sel[o] <= 2'd0;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (gv[o] && out_rdy[o]) begin
                    last_sel[o] <= gnt[o];
                    if (in_tail[gnt[o]] || !p_lock_en) begin
                        st[o]  <= IDLE;
                        ptr[o] <= gnt[o] + 2'd1;
                    end else begin
                        st[o]    <= LOCKED;
                        owner[o] <= gnt[o];
                    end
                end
            end
        end
    end
`ifdef CROSSBAR_ARB_DOMAIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            viol <= 4'd0;
        else
            for (int i = 0; i < 4; i++)
                viol[i] <= in_val[i] && in_domain[i] && !out_domain[in_dest[2*i +: 2]];
    end
`endif
endmodule

// File: tb/tb_crossbar_arb4.sv
// tb_crossbar_arb4: directed and random checks of crossbar_arb4 against a packet-level reference model.
module tb_crossbar_arb4;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_val = 4'hF, in_tail = 4'h0, out_rdy = 4'hF;
    logic [7:0] in_dest = 8'h1B;
    logic [3:0] in_rdy, out_val;
    logic [1:0] sel0, sel1, sel2, sel3;
`ifdef CROSSBAR_ARB_DOMAIN_EN
    logic [3:0] in_domain = 4'h0, out_domain = 4'h0, viol;
`endif
    int n_checks = 0, n_fail = 0;
    int m_locked [4], m_owner [4], m_ptr [4], m_last [4], g [4];

    crossbar_arb4 dut (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_dest(in_dest), .in_tail(in_tail),
        .in_rdy(in_rdy), .out_val(out_val), .out_rdy(out_rdy),
        .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3)
`ifdef CROSSBAR_ARB_DOMAIN_EN
        , .in_domain(in_domain), .out_domain(out_domain), .viol(viol)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_last[o] = 0;
        end
    endtask

    function automatic int dest_of(input int i);
        return int'(in_dest[2*i +: 2]);
    endfunction

    // drive one cycle of inputs and compare outputs with the model's view of that cycle
    task automatic step(input logic [3:0] v, input logic [7:0] d, input logic [3:0] t, input logic [3:0] r);
        logic [3:0] e_val, e_rdy;
        logic [7:0] e_sel;
        @(negedge clk);
        in_val = v; in_dest = d; in_tail = t; out_rdy = r;
        #1;
        e_val = 4'd0; e_rdy = 4'd0; e_sel = 8'd0;
        for (int o = 0; o < 4; o++) begin
            g[o] = -1;
            if (m_locked[o] != 0) begin
                if (in_val[m_owner[o]] && dest_of(m_owner[o]) == o) g[o] = m_owner[o];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int i = (m_ptr[o] + k) % 4;
                    if (g[o] < 0 && in_val[i] && dest_of(i) == o) g[o] = i;
                end
            end
            e_val[o] = g[o] >= 0;
            e_sel[2*o +: 2] = 2'(g[o] >= 0 ? g[o] : m_last[o]);
            for (int i = 0; i < 4; i++)
                if (g[o] == i && out_rdy[o]) e_rdy[i] = 1'b1;
        end
        chk("out_val", {4'd0, out_val}, {4'd0, e_val});
        chk("in_rdy", {4'd0, in_rdy}, {4'd0, e_rdy});
        chk("sel", {sel3, sel2, sel1, sel0}, e_sel);
`ifdef CROSSBAR_ARB_DOMAIN_EN
        chk("viol_idle", {4'd0, viol}, 8'd0);
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        for (int o = 0; o < 4; o++) begin
            if (g[o] >= 0 && out_rdy[o]) begin
                m_last[o] = g[o];
                if (in_tail[g[o]]) begin
                    m_locked[o] = 0;
                    m_ptr[o] = (g[o] + 1) % 4;
                end else begin
                    m_locked[o] = 1;
                    m_owner[o] = g[o];
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_out_val", {4'd0, out_val}, 8'd0);
        chk("reset_in_rdy", {4'd0, in_rdy}, 8'd0);
        chk("reset_sel", {sel3, sel2, sel1, sel0}, 8'd0);
        @(negedge clk);
        in_val = 4'd0;
        #2 reset_n = 1'b1;

        step(4'b0001, 8'h02, 4'b0001, 4'hF);
        chk("single_out_val", {4'd0, out_val}, 8'h04);
        chk("single_sel2", {6'd0, sel2}, 8'd0);
        chk("single_in_rdy", {4'd0, in_rdy}, 8'h01);
        adv();
        step(4'b0011, 8'h0A, 4'b0011, 4'hF);
        chk("ptr2_advanced", {4'd0, in_rdy}, 8'h02);
        adv();

        for (int k = 0; k < 4; k++) begin
            step(4'hF, 8'h55, 4'hF, 4'hF);
            chk("rr_sel1", {6'd0, sel1}, 8'(k));
            chk("rr_in_rdy", {4'd0, in_rdy}, 8'(1 << k));
            adv();
        end

        step(4'b0010, 8'h0C, 4'b0010, 4'hF);
        adv();
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 8'h33, k == 2 ? 4'b0101 : 4'b0001, 4'hF);
            chk("worm_in_rdy", {4'd0, in_rdy}, 8'h04);
            adv();
        end
        step(4'b0001, 8'h33, 4'b0001, 4'hF);
        chk("worm_after_tail", {4'd0, in_rdy}, 8'h01);
        adv();

        for (int k = 0; k < 5; k++) begin
            step(4'b0010, 8'h00, 4'b0010, 4'b1110);
            chk("bp_out_val", {4'd0, out_val}, 8'h01);
            chk("bp_in_rdy", {4'd0, in_rdy}, 8'h00);
            chk("bp_sel0", {6'd0, sel0}, 8'h01);
            adv();
        end
        step(4'b0010, 8'h00, 4'b0010, 4'hF);
        chk("bp_release", {4'd0, in_rdy}, 8'h02);
        adv();
        step(4'b0000, 8'h00, 4'b0000, 4'hF);
        adv();

        step(4'b0100, 8'h10, 4'b0000, 4'hF);
        adv();
        step(4'b0100, 8'h10, 4'b0000, 4'hF);
        #2 reset_n = 1'b0;
        #1;
        chk("async_out_val", {4'd0, out_val}, 8'd0);
        chk("async_in_rdy", {4'd0, in_rdy}, 8'd0);
        chk("async_sel", {sel3, sel2, sel1, sel0}, 8'd0);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(4'b0101, 8'h11, 4'b0101, 4'hF);
        chk("post_reset_winner", {4'd0, in_rdy}, 8'h01);
        adv();

        for (int n = 0; n < 600; n++) begin
            step(4'($urandom), 8'($urandom), ($urandom % 3 == 0) ? 4'd0 : 4'($urandom),
                 ($urandom % 4 == 0) ? 4'($urandom) : 4'hF);
            adv();
        end

`ifdef CROSSBAR_ARB_DOMAIN_EN
        @(negedge clk);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        in_domain = 4'b0010; out_domain = 4'b0000;
        in_val = 4'b0010; in_dest = 8'h00; in_tail = 4'hF; out_rdy = 4'hF;
        #1;
        chk("dom_blocked_val", {4'd0, out_val}, 8'd0);
        chk("dom_blocked_rdy", {4'd0, in_rdy}, 8'd0);
        @(negedge clk);
        in_val = 4'b0001;
        #1;
        chk("dom_viol", {4'd0, viol}, 8'h02);
        chk("dom_low_granted", {4'd0, in_rdy}, 8'h01);
        @(negedge clk);
        #1;
        chk("dom_viol_clear", {4'd0, viol}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
